multicycle_ctrl: RTL and testbench

Multicycle control FSM for the single-issue RV32I datapath. Each fetched instruction is walked through fetch, decode, execute, memory and writeback states. Per state, the block drives the datapath strobes (loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl) and the data-memory strobes. It sits between instruction memory, data memory and the datapath, and is the only source of those control signals.

---
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle RV32I datapath.
// Walks each instruction through IF/ID/EX/(MEM)/WB and drives the datapath
// and data-memory strobes as combinational functions of state, instr, zero_q.
// Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN (illegal opcode
// halts the FSM and sets the sticky illegal flag; otherwise it is a NOP).
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic [2:0]  state,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  state_t      state_reg, state_next;
  logic        zero_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        is_r, is_i, is_lw, is_sw, is_beq, is_legal;
  logic [3:0]  alu_dec;
  logic        busy;

  // Register/immediate fields are consumed by the datapath, not by control.
  logic        unused_fields;
  assign unused_fields = ^{instr[31], instr[29:15], instr[11:7]};

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_beq;

  // ALU operation decode; funct7[5] only matters for SUB (R-type) and SRA/SRAI.
  // funct3=011 (SLTU) has no dedicated ALU code and shares SLT.
  always_comb begin
    alu_dec = ALU_AND;
    if (is_lw || is_sw) begin
      alu_dec = ALU_ADD;
    end else if (is_beq) begin
      alu_dec = ALU_SUB;
    end else if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_dec = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_dec = ALU_SLL;
        3'b010:  alu_dec = ALU_SLT;
        3'b011:  alu_dec = ALU_SLT;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_dec = ALU_OR;
        default: alu_dec = ALU_AND;
      endcase
    end
  end

  // State register and branch-flag capture at the end of EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IF;
      zero_q    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_EX) zero_q <= Zero;
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg;

  // Sticky flag set on the same edge that moves ID into HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  illegal_reg <= 1'b0;
    else if (state_reg == S_ID && !is_legal)   illegal_reg <= 1'b1;
  end

  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  // Next-state sequencing.
  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF:   state_next = S_ID;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_ID:   state_next = is_legal ? S_EX : S_HALT;
`else
      S_ID:   state_next = S_EX;
`endif
      S_EX:   state_next = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:  state_next = S_WB;
      S_WB:   state_next = S_IF;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  // ALU controls are held from ID through WB; zero in IF and HALT.
  assign busy = (state_reg == S_ID) || (state_reg == S_EX) ||
                (state_reg == S_MEM) || (state_reg == S_WB);

  // Per-state strobe outputs.
  always_comb begin
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = busy & (is_i | is_lw | is_sw);
    ALUCtrl  = busy ? alu_dec : 4'b0000;
    if (state_reg == S_MEM) begin
      MemRead  = is_lw;
      MemWrite = is_sw;
    end
    if (state_reg == S_WB) begin
      loadPC   = 1'b1;
      PCSrc    = is_beq & zero_q;
      RegWrite = is_r | is_i | is_lw;
      MemToReg = is_lw;
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized check of multicycle_ctrl against
// an instruction-level reference model (class -> state sequence and strobes).
// Honours MULTICYCLE_CTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic        Zero = 1'b0;
  logic [2:0]  state;
  logic        loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;

  int cmp_cnt = 0;
  int err_cnt = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0050A223;
  localparam logic [31:0] I_BEQ  = 32'h00108463;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  typedef enum int {C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL} cls_t;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .state(state),
    .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Instruction class from the ISA rules.
  function automatic cls_t classify(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'b0110011) return C_R;
    if (op == 7'b0010011) return C_I;
    if (op == 7'b0000011 && f3 == 3'b010) return C_LW;
    if (op == 7'b0100011 && f3 == 3'b010) return C_SW;
    if (op == 7'b1100011 && f3 == 3'b000) return C_BEQ;
    return C_ILL;
  endfunction

  // Reference ALU operation by mnemonic.
  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    cls_t c;
    logic [2:0] f3;
    logic [3:0] by_f3 [8];
    by_f3 = '{4'b0010, 4'b1001, 4'b0100, 4'b0100, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
    c  = classify(ins);
    f3 = ins[14:12];
    if (c == C_LW || c == C_SW) return 4'b0010;
    if (c == C_BEQ) return 4'b0110;
    if (c == C_ILL) return 4'b0000;
    if (f3 == 3'b000 && c == C_R && ins[30]) return 4'b0110;
    if (f3 == 3'b101 && ins[30]) return 4'b1010;
    return by_f3[f3];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for instruction ins in state st.
  task automatic check_cycle(input logic [31:0] ins, input int st, input bit zq);
    cls_t c;
    bit   busy;
    string s;
    c    = classify(ins);
    busy = (st >= 1 && st <= 4);
    s    = $sformatf("ins=%08h st=%0d", ins, st);
    check({"state ", s},    {29'd0, state}, st);
    check({"ALUSrc ", s},   {31'd0, ALUSrc}, busy && (c == C_I || c == C_LW || c == C_SW));
    check({"ALUCtrl ", s},  {28'd0, ALUCtrl}, busy ? ref_alu(ins) : 4'd0);
    check({"MemRead ", s},  {31'd0, MemRead},  st == 3 && c == C_LW);
    check({"MemWrite ", s}, {31'd0, MemWrite}, st == 3 && c == C_SW);
    check({"RegWrite ", s}, {31'd0, RegWrite}, st == 4 && (c == C_R || c == C_I || c == C_LW));
    check({"MemToReg ", s}, {31'd0, MemToReg}, st == 4 && c == C_LW);
    check({"loadPC ", s},   {31'd0, loadPC},   st == 4);
    check({"PCSrc ", s},    {31'd0, PCSrc},    st == 4 && c == C_BEQ && zq);
    check({"illegal ", s},  {31'd0, illegal},  st == 5);
  endtask

  // Run one instruction from IF (called at a negedge with the FSM in IF).
  // abort_st >= 0 asserts reset in that state and returns after release.
  task automatic run_instr(input logic [31:0] ins, input bit z, input bit toggle_wb,
                           input int abort_st);
    int   seq[$];
    cls_t c;
    c     = classify(ins);
    instr = ins;
    seq   = {0, 1};
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    if (c == C_ILL) seq.push_back(5);
    else begin
`else
    begin
`endif
      seq.push_back(2);
      if (c == C_LW || c == C_SW) seq.push_back(3);
      seq.push_back(4);
    end
    $display("instr %08h class=%0d zero=%0b toggle=%0b cycles=%0d", ins, c, z, toggle_wb, seq.size());
    foreach (seq[k]) begin
      if (seq[k] == 2) Zero = z;
      check_cycle(ins, seq[k], z);
      if (seq[k] == 4 && toggle_wb) begin
        Zero = ~z;
        #1;
        check($sformatf("PCSrc_hold ins=%08h", ins), {31'd0, PCSrc}, c == C_BEQ && z);
      end
      if (seq[k] == abort_st) begin
        rst = 1'b0;
        #1;
        check_cycle(ins, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (seq[seq.size()-1] == 5) begin
      repeat (3) begin
        Zero = 1'($urandom);
        check_cycle(ins, 5, 1'b0);
        @(negedge clk);
      end
      rst = 1'b0;
      #1;
      check_cycle(ins, 0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  function automatic logic [31:0] gen(input int kind);
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [31:0] w;
    f3 = 3'($urandom_range(0, 7));
    if (f3 == 3'b011) f3 = 3'b000;
    case (kind)
      0: begin
        f7 = (f3 == 3'b000 || f3 == 3'b101) ? {1'b0, 1'($urandom), 5'd0} : 7'd0;
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
      end
      1: begin
        imm = 12'($urandom);
        if (f3 == 3'b001) imm[11:5] = 7'd0;
        if (f3 == 3'b101) imm[11:5] = {1'b0, 1'($urandom), 5'd0};
        return {imm, 5'($urandom), f3, 5'($urandom), 7'b0010011};
      end
      2: return {12'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0000011};
      3: return {7'($urandom), 5'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0100011};
      4: return {7'($urandom), 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b1100011};
      default: begin
        w = $urandom;
        for (int t = 0; t < 50 && classify(w) != C_ILL; t++) w = $urandom;
        if (classify(w) != C_ILL) w = I_ILL;
        return w;
      end
    endcase
  endfunction

  initial begin
    rst   = 1'b0;
    instr = I_ADD;
    Zero  = 1'b0;
    repeat (2) @(negedge clk);
    check_cycle(I_ADD, 0, 1'b0);
    rst = 1'b1;

    // Reset mid-EX of ADD, then a full ADD proves IF->ID after release.
    run_instr(I_ADD, 1'b0, 1'b0, 2);
    run_instr(I_ADD, 1'b0, 1'b0, -1);
    run_instr(I_LW,  1'b0, 1'b0, -1);
    run_instr(I_SW,  1'b1, 1'b0, -1);
    run_instr(I_BEQ, 1'b1, 1'b0, -1);
    run_instr(I_BEQ, 1'b0, 1'b1, -1);
    run_instr(I_BEQ, 1'b1, 1'b1, -1);
    run_instr(I_ILL, 1'b1, 1'b0, -1);
    // Reset during WB of LW: FSM must restart cleanly at IF.
    run_instr(I_LW,  1'b0, 1'b0, 4);
    run_instr(I_ADD, 1'b0, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      run_instr(gen($urandom_range(0, 5)), 1'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
